// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arbiter
// Brief    : Single-outstanding memory port arbiter between instruction fetch
//            and the load/store data path, with fetch starvation protection.
// Revision : 1.0
// ============================================================================
module lsu_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [1:0]        data_size,
    output logic              data_ack,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int                 c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_starve;
    logic               w_fetch_wins;
    logic               w_complete;

    // Data has priority unless fetch is alone or has been passed over too often.
    assign w_fetch_wins = fetch_req & (~data_req | (r_starve >= c_LIMIT));
    assign w_complete   = ((r_state == c_ISSUE) & mem_ready & mem_done) |
                          ((r_state == c_WAIT) & mem_done);
    assign busy         = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_starve    <= '0;
            fetch_ack   <= 1'b0;
            data_ack    <= 1'b0;
            fetch_done  <= 1'b0;
            data_done   <= 1'b0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_size    <= 2'd0;
            owner       <= 1'b0;
        end else begin
            fetch_ack  <= 1'b0;
            data_ack   <= 1'b0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (fetch_req | data_req) begin
                        r_state <= c_ISSUE;
                        mem_req <= 1'b1;
                        owner   <= ~w_fetch_wins;
                        if (w_fetch_wins) begin
                            fetch_ack <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_size  <= 2'd3;
                            mem_addr  <= fetch_addr;
                            mem_wdata <= '0;
                            r_starve  <= '0;
                        end else begin
                            data_ack  <= 1'b1;
                            mem_we    <= data_we;
                            mem_size  <= data_size;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                            if (fetch_req && (r_starve < c_LIMIT)) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end
                    end
                end
                c_ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_state <= mem_done ? c_RESP : c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (mem_done) begin
                        r_state <= c_RESP;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Read data is captured on the completing edge so it is valid with done.
            if (w_complete) begin
                if (owner) begin
                    data_done  <= 1'b1;
                    data_rdata <= mem_rdata;
                end else begin
                    fetch_done  <= 1'b1;
                    fetch_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_arbiter
// Brief    : Transaction-level randomized self-checking bench for lsu_arbiter.
// Revision : 1.0
// ============================================================================
module tb_lsu_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_ack, fetch_done;
    logic [63:0] fetch_rdata;
    logic        data_req, data_we;
    logic [63:0] data_addr, data_wdata;
    logic [1:0]  data_size;
    logic        data_ack, data_done;
    logic [63:0] data_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ready, mem_done;
    logic [63:0] mem_rdata;
    logic        busy, owner;

    int n_checks = 0;
    int n_errors = 0;
    int starve   = 0;
    bit hold_data = 1'b0;

    lsu_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_size(data_size), .data_ack(data_ack),
        .data_done(data_done), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ready(mem_ready), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_fetch();
        fetch_req  = 1'b1;
        fetch_addr = {$urandom, $urandom};
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_we    = 1'($urandom_range(0, 1));
        data_addr  = {$urandom, $urandom};
        data_wdata = {$urandom, $urandom};
        data_size  = 2'($urandom_range(0, 3));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_acks"}, {fetch_ack, data_ack}, 0);
        chk({tag, "_dones"}, {fetch_done, data_done}, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_size"}, mem_size, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_fetch_rdata"}, fetch_rdata, 0);
        chk({tag, "_data_rdata"}, data_rdata, 0);
    endtask

    // One complete transaction: grant, rd stalled ISSUE cycles, then either a
    // same-cycle ready+done or wd extra WAIT cycles; optional reset in WAIT.
    task automatic round(input int rd, input int wd, input bit same, input bit rst_mid,
                         input logic [63:0] rdata);
        bit          fw;
        logic        e_we;
        logic [1:0]  e_size;
        logic [63:0] e_addr, e_wdata;

        fw = fetch_req && (!data_req || starve >= STARVE_LIMIT);
        if (fw) begin
            e_we = 1'b0; e_size = 2'd3; e_addr = fetch_addr; e_wdata = 64'd0;
            starve = 0;
        end else begin
            e_we = data_we; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
            if (fetch_req && starve < STARVE_LIMIT) starve++;
        end

        step();
        chk("grant_fetch_ack", fetch_ack, fw);
        chk("grant_data_ack", data_ack, !fw);
        chk("grant_busy", busy, 1);
        chk("grant_owner", owner, !fw);
        chk("issue_mem_req", mem_req, 1);
        chk("issue_addr", mem_addr, e_addr);
        chk("issue_we", mem_we, e_we);
        chk("issue_size", mem_size, e_size);
        chk("issue_wdata", mem_wdata, e_wdata);
        chk("grant_dones", {fetch_done, data_done}, 0);

        if (fw) begin
            fetch_req = 1'b0;
            if ($urandom_range(0, 1) == 1) new_fetch();
        end else begin
            data_req = 1'b0;
            if (hold_data || $urandom_range(0, 1) == 1) new_data();
        end

        mem_ready = 1'b0;
        for (int i = 0; i < rd; i++) begin
            mem_done = 1'($urandom_range(0, 1));
            step();
            chk("stall_mem_req", mem_req, 1);
            chk("stall_addr", mem_addr, e_addr);
            chk("stall_fields", {mem_we, mem_size}, {e_we, e_size});
            chk("stall_wdata", mem_wdata, e_wdata);
            chk("stall_acks", {fetch_ack, data_ack}, 0);
            chk("stall_dones", {fetch_done, data_done}, 0);
        end

        mem_ready = 1'b1;
        mem_done  = same;
        mem_rdata = rdata;
        step();
        mem_ready = 1'b0;
        mem_done  = 1'b0;

        if (!same) begin
            chk("wait_mem_req", mem_req, 0);
            chk("wait_busy", busy, 1);
            chk("wait_dones", {fetch_done, data_done}, 0);
            if (rst_mid) begin
                rst = 1'b1;
                fetch_req = 1'b0;
                data_req  = 1'b0;
                step();
                starve = 0;
                chk_reset_state("rstmid");
                rst       = 1'b0;
                mem_done  = 1'b1;
                mem_rdata = rdata;
                step();
                mem_done = 1'b0;
                chk("rstmid_stray_busy", busy, 0);
                chk("rstmid_stray_dones", {fetch_done, data_done}, 0);
                chk("rstmid_stray_mem_req", mem_req, 0);
                return;
            end
            for (int i = 0; i < wd; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                step();
                chk("wait_mem_req", mem_req, 0);
                chk("wait_dones", {fetch_done, data_done}, 0);
                chk("wait_acks", {fetch_ack, data_ack}, 0);
            end
            mem_ready = 1'b0;
            mem_done  = 1'b1;
            mem_rdata = rdata;
            step();
        end

        mem_ready = 1'($urandom_range(0, 1));
        mem_done  = 1'($urandom_range(0, 1));
        chk("resp_fetch_done", fetch_done, fw);
        chk("resp_data_done", data_done, !fw);
        if (fw) chk("resp_fetch_rdata", fetch_rdata, rdata);
        else    chk("resp_data_rdata", data_rdata, rdata);
        chk("resp_busy", busy, 1);
        chk("resp_mem_req", mem_req, 0);
        chk("resp_acks", {fetch_ack, data_ack}, 0);

        step();
        chk("idle_busy", busy, 0);
        chk("idle_dones", {fetch_done, data_done}, 0);
        chk("idle_acks", {fetch_ack, data_ack}, 0);
        chk("idle_owner", owner, !fw);
        mem_ready = 1'($urandom_range(0, 1));
        mem_done  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_size = 2'd0;
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;

        fetch_req = 1'b1; fetch_addr = 64'h40;
        round(0, 1, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D);

        if (!fetch_req) new_fetch();
        data_req = 1'b1; data_we = 1'b1; data_addr = 64'h100; data_wdata = 64'h55; data_size = 2'd1;
        round(1, 0, 1'b1, 1'b0, {$urandom, $urandom});
        round(0, 0, 1'b1, 1'b0, {$urandom, $urandom});

        hold_data = 1'b1;
        if (!fetch_req) new_fetch();
        if (!data_req) new_data();
        repeat (12) begin
            if (!fetch_req) new_fetch();
            round(0, 0, 1'b1, 1'b0, {$urandom, $urandom});
        end
        hold_data = 1'b0;

        if (!fetch_req) new_fetch();
        round(5, 0, 1'b1, 1'b0, {$urandom, $urandom});

        if (!data_req) new_data();
        round(2, 1, 1'b0, 1'b1, {$urandom, $urandom});
        new_fetch();
        round(0, 0, 1'b1, 1'b0, {$urandom, $urandom});

        for (int n = 0; n < 300; n++) begin
            if (!fetch_req && $urandom_range(0, 1) == 1) new_fetch();
            if (!data_req && $urandom_range(0, 1) == 1) new_data();
            if (!fetch_req && !data_req) new_data();
            round($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
